// File: rtl/dma_pkg.sv
// Shared types and default window constants for the byte-copy DMA.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dma_pkg;

    // Default ROM (source) and RAM (destination) windows
    localparam logic [31:0] DEF_SRC_LO = 32'h4000;
    localparam logic [31:0] DEF_DST_LO = 32'h4600;
    localparam int unsigned DEF_WIN_SZ = 256;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        READ,
        WRITE,
        FIN
    } state_t;

endpackage

// File: rtl/dma_bounds.sv
// Window check: flags a copy whose source or destination range leaves its window.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are stable.
module dma_bounds #(
    parameter int unsigned           ADDR_W = 32,
    parameter logic [ADDR_W-1:0]     SRC_LO = ADDR_W'(dma_pkg::DEF_SRC_LO),
    parameter logic [ADDR_W-1:0]     DST_LO = ADDR_W'(dma_pkg::DEF_DST_LO),
    parameter int unsigned           WIN_SZ = dma_pkg::DEF_WIN_SZ
) (
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [8:0]        length,
    output logic              bad
);

    // One extra bit on every sum so base+length near the top of the map cannot wrap
    logic [ADDR_W:0] len_x;
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic [ADDR_W:0] src_lim;
    logic [ADDR_W:0] dst_lim;

    // Compare both ranges against their window limits
    always_comb begin
        len_x   = {{(ADDR_W-8){1'b0}}, length};
        src_end = {1'b0, src_base} + len_x;
        dst_end = {1'b0, dst_base} + len_x;
        src_lim = {1'b0, SRC_LO} + (ADDR_W+1)'(WIN_SZ);
        dst_lim = {1'b0, DST_LO} + (ADDR_W+1)'(WIN_SZ);
        bad     = (src_base < SRC_LO) || (src_end > src_lim) ||
                  (dst_base < DST_LO) || (dst_end > dst_lim);
    end

endmodule

// File: rtl/dma_copy.sv
// Byte-wise copy engine: reads a ROM window and writes a RAM window over a shared bus.
// Latency: N bytes take 2N+3 cycles from start to done with uninterrupted grant.
// Backpressure: a cycle without bus_gnt is discarded and the engine re-arbitrates, repeating the byte.
module dma_copy
    import dma_pkg::*;
#(
    parameter int unsigned           ADDR_W = 32,
    parameter logic [ADDR_W-1:0]     SRC_LO = ADDR_W'(DEF_SRC_LO),
    parameter logic [ADDR_W-1:0]     DST_LO = ADDR_W'(DEF_DST_LO),
    parameter int unsigned           WIN_SZ = DEF_WIN_SZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [8:0]        length,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] DataAdr,
    output logic [ADDR_W-1:0] WriteData,
    output logic              MemWrite,
    input  logic [ADDR_W-1:0] ReadData,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [8:0]        rem_q, rem_d;
    logic [7:0]        byte_q, byte_d;
    logic              err_q, err_d;
    logic              range_bad;
    logic              rd_go;
    logic              wr_go;
    logic              unused_rd_hi;

    // Only the low byte of the bus is meaningful for a byte copy
    assign unused_rd_hi = ^ReadData[ADDR_W-1:8];

    // Checks the latched request, so the window test sees stable values in CHECK
    dma_bounds #(
        .ADDR_W (ADDR_W),
        .SRC_LO (SRC_LO),
        .DST_LO (DST_LO),
        .WIN_SZ (WIN_SZ)
    ) u_bounds (
        .src_base (src_ptr_q),
        .dst_base (dst_ptr_q),
        .length   (rem_q),
        .bad      (range_bad)
    );

    // State and datapath registers; reset abandons any partial copy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            byte_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
        end
    end

    // A bus cycle only counts when the arbiter grants it in the same cycle
    assign rd_go = (state_q == READ)  && bus_gnt;
    assign wr_go = (state_q == WRITE) && bus_gnt;

    // Next-state and datapath updates; an ungranted READ/WRITE falls back to REQ unchanged
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        byte_d    = byte_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CHECK;
                    src_ptr_d = src_base;
                    dst_ptr_d = dst_base;
                    rem_d     = length;
                    err_d     = 1'b0;
                end
            end
            CHECK: begin
                if (range_bad) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else if (rem_q == 9'd0) begin
                    state_d = FIN;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_go) begin
                    byte_d  = ReadData[7:0];
                    state_d = WRITE;
                end else begin
                    state_d = REQ;
                end
            end
            WRITE: begin
                if (wr_go) begin
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    rem_d     = rem_q - 9'd1;
                    state_d   = (rem_q == 9'd1) ? FIN : READ;
                end else begin
                    state_d = REQ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs stay at zero unless a granted read or write is in progress
    always_comb begin
        bus_req   = (state_q == REQ) || (state_q == READ) || (state_q == WRITE);
        DataAdr   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        if (rd_go) begin
            DataAdr = src_ptr_q;
        end else if (wr_go) begin
            DataAdr   = dst_ptr_q;
            WriteData = {{(ADDR_W-8){1'b0}}, byte_q};
            MemWrite  = 1'b1;
        end
        busy = (state_q != IDLE) && (state_q != FIN);
        done = (state_q == FIN);
        err  = err_q;
    end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: expected writes and done/err results are queued at issue time.
// Latency: checks done arrives 2N+3 cycles after start, or later when grant is withheld.
// Backpressure: drops bus_gnt on selected cycles and checks the interrupted byte is repeated.
module tb_dma_copy;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [8:0]  length;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        busy;
    logic        done;
    logic        err;

    int          vec_cnt  = 0;
    int          fail_cnt = 0;
    int          wr_cnt   = 0;
    bit          breq_seen = 1'b0;
    bit          stim_done = 1'b0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic        exp_err_q[$];

    dma_copy u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .length    (length),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a fixed per-address pattern so misplaced bytes are visible
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    assign ReadData = {24'h0, rom_byte(DataAdr)};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".bus_req"},   {31'h0, bus_req},  32'h0);
        chk({nm, ".MemWrite"},  {31'h0, MemWrite}, 32'h0);
        chk({nm, ".busy"},      {31'h0, busy},     32'h0);
        chk({nm, ".done"},      {31'h0, done},     32'h0);
        chk({nm, ".err"},       {31'h0, err},      32'h0);
        chk({nm, ".DataAdr"},   DataAdr,           32'h0);
        chk({nm, ".WriteData"}, WriteData,         32'h0);
    endtask

    // Issue one copy; drop_cyc withholds grant for that cycle, poke_cyc pulses a stray start
    task automatic do_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                           input logic [8:0] n, input bit bad, input int drop_cyc,
                           input int poke_cyc, input int exp_cyc);
        int  done_cyc;
        bit  busy_at_done;
        wr_cnt    = 0;
        breq_seen = 1'b0;
        if (!bad) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_adr_q.push_back(d + 32'(i));
                exp_dat_q.push_back({24'h0, rom_byte(s + 32'(i))});
            end
        end
        exp_err_q.push_back(bad);
        @(posedge clk); #1;
        start    = 1'b1;
        src_base = s;
        dst_base = d;
        length   = n;
        done_cyc     = 0;
        busy_at_done = 1'b1;
        for (int c = 1; c <= 600 && done_cyc == 0; c++) begin
            @(posedge clk); #1;
            start   = (c == poke_cyc);
            bus_gnt = (c != drop_cyc);
            if (c == poke_cyc) begin
                src_base = 32'h4000;
                dst_base = 32'h4600;
                length   = 9'd1;
            end
            #1;
            if (c == 1) begin
                chk({nm, ".busy_c1"}, {31'h0, busy}, 32'h1);
                chk({nm, ".err_c1"},  {31'h0, err},  32'h0);
            end
            if (c == drop_cyc) begin
                chk({nm, ".nogrant_req"},  {31'h0, bus_req},  32'h1);
                chk({nm, ".nogrant_wr"},   {31'h0, MemWrite}, 32'h0);
                chk({nm, ".nogrant_adr"},  DataAdr,           32'h0);
            end
            if (done) begin
                done_cyc     = c;
                busy_at_done = busy;
            end
        end
        start   = 1'b0;
        bus_gnt = 1'b1;
        chk({nm, ".done_cycle"},   done_cyc, exp_cyc);
        chk({nm, ".busy_at_done"}, {31'h0, busy_at_done}, 32'h0);
        chk({nm, ".err"},          {31'h0, err}, {31'h0, bad});
        @(posedge clk); #2;
        chk({nm, ".done_pulse"},   {31'h0, done}, 32'h0);
        chk({nm, ".writes"},       wr_cnt, bad ? 0 : int'(n));
        chk({nm, ".pending"},      exp_adr_q.size(), 0);
        if (n == 9'd0 || bad) begin
            chk({nm, ".no_bus_req"}, {31'h0, breq_seen}, 32'h0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        bus_gnt  = 1'b1;
        src_base = '0;
        dst_base = '0;
        length   = '0;
        fork
            begin : stim
                #12;
                chk_zero("reset");
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                chk_zero("idle");

                do_copy("len4",    32'h4000, 32'h4600, 9'd4,   1'b0, 0, 0, 11);
                do_copy("len0",    32'h4010, 32'h4610, 9'd0,   1'b0, 0, 0, 2);
                do_copy("src_top", 32'h40FF, 32'h4600, 9'd2,   1'b1, 0, 0, 2);
                repeat (3) @(posedge clk);
                #1;
                chk("err_sticky", {31'h0, err}, 32'h1);
                do_copy("dst_top", 32'h4000, 32'h46FF, 9'd2,   1'b1, 0, 0, 2);
                do_copy("src_low", 32'h3FFF, 32'h4600, 9'd1,   1'b1, 0, 0, 2);
                do_copy("dst_low", 32'h4000, 32'h45FF, 9'd1,   1'b1, 0, 0, 2);
                do_copy("edge_ok", 32'h40FC, 32'h46FC, 9'd4,   1'b0, 0, 0, 11);
                do_copy("gnt_drop",32'h4020, 32'h4620, 9'd3,   1'b0, 6, 0, 12);
                do_copy("req_wait",32'h4030, 32'h4630, 9'd2,   1'b0, 2, 0, 8);
                do_copy("poke",    32'h4040, 32'h4640, 9'd3,   1'b0, 0, 4, 9);
                do_copy("full",    32'h4000, 32'h4600, 9'd256, 1'b0, 0, 0, 515);

                // Reset while the second byte is being read: only byte 0 lands, no done
                wr_cnt = 0;
                exp_adr_q.push_back(32'h4600);
                exp_dat_q.push_back({24'h0, rom_byte(32'h4000)});
                @(posedge clk); #1;
                start    = 1'b1;
                src_base = 32'h4000;
                dst_base = 32'h4600;
                length   = 9'd4;
                for (int c = 1; c <= 5; c++) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                reset = 1'b0;
                #1;
                chk_zero("mid_reset");
                @(posedge clk); #1;
                chk_zero("held_reset");
                reset = 1'b1;
                chk("mid_reset.writes",  wr_cnt, 1);
                chk("mid_reset.pending", exp_adr_q.size(), 0);
                do_copy("after_rst", 32'h4080, 32'h4680, 9'd2, 1'b0, 0, 0, 7);

                chk("done_pending", exp_err_q.size(), 0);
                stim_done = 1'b1;
            end
            begin : mon
                while (!stim_done) begin
                    @(negedge clk);
                    if (bus_req) breq_seen = 1'b1;
                    if (MemWrite) begin
                        wr_cnt++;
                        if (exp_adr_q.size() == 0) begin
                            vec_cnt++;
                            fail_cnt++;
                            $display("FAIL unexpected_write: got adr %h dat %h, expected none",
                                     DataAdr, WriteData);
                        end else begin
                            chk("write_adr", DataAdr,   exp_adr_q.pop_front());
                            chk("write_dat", WriteData, exp_dat_q.pop_front());
                        end
                    end
                    if (done) begin
                        if (exp_err_q.size() == 0) begin
                            vec_cnt++;
                            fail_cnt++;
                            $display("FAIL unexpected_done: got done err=%0b, expected none", err);
                        end else begin
                            chk("done_err", {31'h0, err}, {31'h0, exp_err_q.pop_front()});
                        end
                    end
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter ADDR_W, default 32, bus address/data width.
REQ-002 Parameter SRC_LO, default 32'h4000, lowest legal source address (ROM window).
REQ-003 Parameter DST_LO, default 32'h4600, lowest legal destination address (RAM window).
REQ-004 Parameter WIN_SZ, default 256, window size in bytes for both windows.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-008 src_base  input  ADDR_W  first source byte address, sampled with start.
REQ-009 dst_base  input  ADDR_W  first destination byte address, sampled with start.
REQ-010 length  input  9  byte count 0..256, sampled with start.
REQ-011 bus_req  output  1  request for the data bus.
REQ-012 bus_gnt  input  1  arbiter grant; the block drives the bus only while bus_req and bus_gnt are both high.
REQ-013 DataAdr  output  ADDR_W  bus address.
REQ-014 WriteData  output  ADDR_W  bus write data, {24'b0, byte}.
REQ-015 MemWrite  output  1  bus write strobe.
REQ-016 ReadData  input  ADDR_W  combinational read data for DataAdr; bits [7:0] used.
REQ-017 busy  output  1  high from the cycle after an accepted start until done.
REQ-018 done  output  1  one-cycle pulse on completion or error.
REQ-019 err  output  1  sticky error flag; cleared by the next accepted start.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, REQ, READ, WRITE, FIN.
- IDLE->CHECK on start; latches src_base, dst_base, length; clears err.
REQ-021 CHECK (1 cycle) SHALL go to FIN with err=1 if any of the following holds; otherwise it SHALL go to FIN with err=0 when length==0, else to REQ:
- src_base<SRC_LO
- src_base+length>SRC_LO+WIN_SZ
- dst_base<DST_LO
- dst_base+length>DST_LO+WIN_SZ
REQ-022 Bound arithmetic SHALL use ADDR_W+1 bits so that the additions cannot wrap.
REQ-023 bus_req SHALL be high in REQ, READ and WRITE, and low otherwise.
REQ-024 REQ SHALL go to READ in the cycle after bus_gnt is sampled high.
REQ-025 READ: DataAdr=src_ptr, MemWrite=0; ReadData[7:0] SHALL be captured into byte_q at the clock edge; then go to WRITE.
REQ-026 WRITE: DataAdr=dst_ptr, WriteData={24'b0,byte_q}, MemWrite=1; at the edge, src_ptr and dst_ptr SHALL increment by 1 and remaining SHALL decrement by 1.
- remaining becomes 0: go to FIN.
- otherwise: go to READ.
REQ-027 Throughput SHALL be 2 cycles per byte under continuous grant; an N-byte copy SHALL take 2N+3 cycles from the start edge to the done pulse with immediate grant.
REQ-028 If bus_gnt is low in READ or WRITE, that cycle SHALL NOT take effect: MemWrite forced 0, no capture, no increment, and the state SHALL return to REQ while retaining pointers; the interrupted byte SHALL be repeated from READ.
REQ-029 FIN SHALL assert done for one cycle, drop busy, and return to IDLE.
REQ-030 When not driving the bus, DataAdr and WriteData SHALL be 0 and MemWrite SHALL be 0.
REQ-031 start while not IDLE SHALL be ignored.
REQ-032 Pointers SHALL never leave the validated windows; no wrap-around is possible after CHECK passes.

Reset
REQ-033 reset low SHALL asynchronously force the following, regardless of any in-flight transfer (the partial copy is abandoned, no done pulse):
- state=IDLE
- bus_req=0, MemWrite=0, busy=0, done=0, err=0
- DataAdr=0, WriteData=0
- internal pointers, counter and byte_q=0

Structure
REQ-034 A shared package dma_pkg SHALL hold the state enum and the default window constants 32'h4000, 32'h4600 and 256.
REQ-035 A single sub-module dma_bounds SHALL implement the combinational window check of REQ-021.

Verification
REQ-036 start, src=0x4000, dst=0x4600, len=4, grant tied high -> 4 writes to 0x4600..0x4603 with ROM bytes; done at cycle 11.
REQ-037 len=0 -> no bus_req, no MemWrite, done after 2 cycles, err=0.
REQ-038 src=0x40FF, len=2 -> err=1, done pulse, MemWrite never asserted.
REQ-039 len=3, bus_gnt low during the second WRITE -> that byte is re-read and written once with correct data, no duplicate address skipped, total writes=3.
REQ-040 reset low mid-copy at byte 2 -> all outputs 0 next sample; a new start afterwards completes normally.
REQ-041 start pulsed while busy -> ignored; the original transfer completes unchanged.
